// File: rtl/uart_pkg.sv
// Shared definitions for the oversampled UART receiver (and the transmitter
// that will reuse the FIFO): FSM state encoding, parity mode codes,
// oversampling phase constants and small helper functions.
// No ports (package).
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP1 = 3'd3,
        STOP2 = 3'd4
    } RxState;

    localparam logic [1:0] PARITY_SPACE = 2'b00;
    localparam logic [1:0] PARITY_ODD   = 2'b01;
    localparam logic [1:0] PARITY_EVEN  = 2'b10;
    localparam logic [1:0] PARITY_MARK  = 2'b11;

    localparam int OVERSAMPLE    = 16;
    localparam int BITS_PER_CHAR = 11;
    localparam int DATA_WIDTH    = 9;
    localparam int ENTRY_WIDTH   = DATA_WIDTH + 2;

    localparam logic [3:0] SAMPLE_PHASE_A = 4'd7;
    localparam logic [3:0] SAMPLE_PHASE_B = 4'd8;
    localparam logic [3:0] SAMPLE_PHASE_C = 4'd9;
    localparam logic [3:0] ADVANCE_PHASE  = 4'd15;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // bits holds only the received data and parity bits (everything above is
    // zero), so a plain reduction XOR gives the even/odd check.
    function automatic logic parityMismatch(input logic [8:0] bits,
                                            input logic [3:0] parityPos,
                                            input logic [1:0] mode);
        logic result;
        case (mode)
            PARITY_SPACE: result = bits[parityPos];
            PARITY_MARK:  result = ~bits[parityPos];
            PARITY_EVEN:  result = ^bits;
            default:      result = ~(^bits);
        endcase
        return result;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous first-word-fall-through FIFO.
// Ports:
//   clk, rst      - clock, synchronous active-low reset
//   push/pushData - write request and entry
//   pop           - read request (ignored while empty)
//   popData       - head entry, zero while empty
//   full, empty   - occupancy flags
//   count         - number of stored entries
// A push while full is accepted only when a pop happens in the same cycle.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4,
    parameter int WIDTH      = ENTRY_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [WIDTH-1:0]      pushData,
    input  logic                  pop,
    output logic [WIDTH-1:0]      popData,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wrPtr;
    logic [DEPTH_LOG2-1:0] rdPtr;
    logic [DEPTH_LOG2:0]   countReg;
    logic                  doPush;
    logic                  doPop;

    assign empty  = (countReg == '0);
    assign full   = (countReg == DEPTH_COUNT);
    assign count  = countReg;
    assign doPop  = pop && !empty;
    assign doPush = push && (!full || doPop);
    assign popData = empty ? '0 : mem[rdPtr];

    always_ff @(posedge clk) begin
        if (!rst) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            countReg <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + DEPTH_LOG2'(1);
            if (doPop)  rdPtr <= rdPtr + DEPTH_LOG2'(1);
            case ({doPush, doPop})
                2'b10:   countReg <= countReg + (DEPTH_LOG2 + 1)'(1);
                2'b01:   countReg <= countReg - (DEPTH_LOG2 + 1)'(1);
                default: countReg <= countReg;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible once counted.
    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr] <= pushData;
    end

endmodule

// File: rtl/uart_rx_oversampled.sv
// 16x-oversampled UART receiver with majority-vote bit sampling, a receive
// FIFO carrying per-character parity/framing status, sticky overflow and
// break flags, and a line-silence indicator.
// Ports:
//   clk, rst          - system clock, synchronous active-low reset
//   rx                - asynchronous serial input (idle high)
//   dataBits, hasParity, parityMode, extraStopBit, clockDivisor
//                     - frame format, captured at each start edge
//   dataOut, parityErrorOut, frameErrorOut, dataValid, dataReady, fifoCount
//                     - FWFT FIFO head and handshake
//   overflow, breakDetected, clearFlags - sticky status and its clear
//   silence           - line idle for SILENCE_CHARS character times
//
// state | meaning
// IDLE  | waiting for a falling edge on rxSync
// START | checking the start bit, abort on a high vote
// DATA  | shifting data and parity bits in LSB first
// STOP1 | checking first stop bit, push/break decided at phase 9
// STOP2 | checking second stop bit, push at phase 9
module uart_rx_oversampled
    import uart_pkg::*;
#(
    parameter int CLOCK_DIVISOR_WIDTH = 16,
    parameter int FIFO_DEPTH_LOG2     = 4,
    parameter int SILENCE_CHARS       = 3
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           rx,
    input  logic [1:0]                     dataBits,
    input  logic                           hasParity,
    input  logic [1:0]                     parityMode,
    input  logic                           extraStopBit,
    input  logic [CLOCK_DIVISOR_WIDTH-1:0] clockDivisor,
    output logic [8:0]                     dataOut,
    output logic                           parityErrorOut,
    output logic                           frameErrorOut,
    output logic                           dataValid,
    input  logic                           dataReady,
    output logic [FIFO_DEPTH_LOG2:0]       fifoCount,
    output logic                           overflow,
    output logic                           breakDetected,
    input  logic                           clearFlags,
    output logic                           silence
);

    localparam int SILENCE_TICKS = SILENCE_CHARS * BITS_PER_CHAR * OVERSAMPLE;
    localparam int SIL_W = $clog2(SILENCE_TICKS + 1);
    localparam logic [SIL_W-1:0] SILENCE_MAX = SIL_W'(SILENCE_TICKS);

    RxState state, nextState;

    logic rxMeta, rxSync, rxPrev;
    logic fallingEdge;

    logic [1:0]                     cfgDataBits;
    logic                           cfgHasParity;
    logic [1:0]                     cfgParityMode;
    logic                           cfgExtraStop;
    logic [CLOCK_DIVISOR_WIDTH-1:0] cfgDivisor;

    logic [CLOCK_DIVISOR_WIDTH-1:0] tickCnt;
    logic [3:0]                     phase;
    logic                           tick;
    logic                           votePoint;
    logic                           advancePoint;
    logic                           sampA, sampB;
    logic                           vote;

    logic [8:0] shiftReg;
    logic [3:0] bitIdx;
    logic [3:0] lastBitIdx;
    logic [3:0] parityPos;
    logic       lastBit;

    logic startDetect;
    logic shiftEn;
    logic bitAdvance;
    logic pushChar;
    logic pushFrameErr;
    logic setBreak;

    logic [ENTRY_WIDTH-1:0]   pushData;
    logic [ENTRY_WIDTH-1:0]   headData;
    logic                     fifoFull;
    logic                     fifoEmpty;
    logic                     fifoPop;
    logic                     parityErr;
    logic                     overflowSet;
    logic [SIL_W-1:0]         silenceCnt;

    // Synchroniser resets to the idle level so reset release never looks
    // like a start edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rxMeta <= 1'b1;
            rxSync <= 1'b1;
            rxPrev <= 1'b1;
        end else begin
            rxMeta <= rx;
            rxSync <= rxMeta;
            rxPrev <= rxSync;
        end
    end

    assign fallingEdge  = rxPrev & ~rxSync;
    assign tick         = (tickCnt == cfgDivisor);
    assign votePoint    = tick && (phase == SAMPLE_PHASE_C);
    assign advancePoint = tick && (phase == ADVANCE_PHASE);
    assign vote         = majority3(sampA, sampB, rxSync);

    assign lastBitIdx = 4'd4 + {2'b00, cfgDataBits} + {3'b000, cfgHasParity};
    assign parityPos  = 4'd5 + {2'b00, cfgDataBits};
    assign lastBit    = (bitIdx == lastBitIdx);

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= nextState;
    end

    always_comb begin
        nextState    = state;
        startDetect  = 1'b0;
        shiftEn      = 1'b0;
        bitAdvance   = 1'b0;
        pushChar     = 1'b0;
        pushFrameErr = 1'b0;
        setBreak     = 1'b0;
        case (state)
            IDLE: begin
                if (fallingEdge) begin
                    startDetect = 1'b1;
                    nextState   = START;
                end
            end
            START: begin
                if (votePoint && vote)  nextState = IDLE;
                else if (advancePoint)  nextState = DATA;
            end
            DATA: begin
                if (votePoint) shiftEn = 1'b1;
                if (advancePoint) begin
                    bitAdvance = 1'b1;
                    if (lastBit) nextState = STOP1;
                end
            end
            STOP1: begin
                if (votePoint) begin
                    if (!vote) begin
                        // An all-zero character with a low stop bit is a break.
                        if (shiftReg == '0) begin
                            setBreak = 1'b1;
                        end else begin
                            pushChar     = 1'b1;
                            pushFrameErr = 1'b1;
                        end
                        nextState = IDLE;
                    end else if (!cfgExtraStop) begin
                        pushChar  = 1'b1;
                        nextState = IDLE;
                    end
                end else if (advancePoint) begin
                    // Only reachable after a good first stop with two stops.
                    nextState = STOP2;
                end
            end
            STOP2: begin
                if (votePoint) begin
                    pushChar     = 1'b1;
                    pushFrameErr = ~vote;
                    nextState    = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cfgDataBits   <= '0;
            cfgHasParity  <= 1'b0;
            cfgParityMode <= '0;
            cfgExtraStop  <= 1'b0;
            cfgDivisor    <= '0;
            tickCnt       <= '0;
            phase         <= '0;
            sampA         <= 1'b0;
            sampB         <= 1'b0;
            shiftReg      <= '0;
            bitIdx        <= '0;
        end else begin
            if (startDetect) begin
                cfgDataBits   <= dataBits;
                cfgHasParity  <= hasParity;
                cfgParityMode <= parityMode;
                cfgExtraStop  <= extraStopBit;
                cfgDivisor    <= clockDivisor;
                tickCnt       <= '0;
                phase         <= '0;
                shiftReg      <= '0;
                bitIdx        <= '0;
            end else begin
                if (tick) begin
                    tickCnt <= '0;
                    phase   <= phase + 4'd1;
                end else begin
                    tickCnt <= tickCnt + CLOCK_DIVISOR_WIDTH'(1);
                end
                if (shiftEn)    shiftReg[bitIdx] <= vote;
                if (bitAdvance) bitIdx <= bitIdx + 4'd1;
            end
            if (tick && phase == SAMPLE_PHASE_A) sampA <= rxSync;
            if (tick && phase == SAMPLE_PHASE_B) sampB <= rxSync;
        end
    end

    assign parityErr = cfgHasParity && parityMismatch(shiftReg, parityPos, cfgParityMode);
    assign pushData  = {pushFrameErr, parityErr, shiftReg};
    assign fifoPop   = dataReady && !fifoEmpty;

    uart_rx_fifo #(
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2),
        .WIDTH      (ENTRY_WIDTH)
    ) rxFifo (
        .clk      (clk),
        .rst      (rst),
        .push     (pushChar),
        .pushData (pushData),
        .pop      (fifoPop),
        .popData  (headData),
        .full     (fifoFull),
        .empty    (fifoEmpty),
        .count    (fifoCount)
    );

    assign dataOut        = headData[8:0];
    assign parityErrorOut = headData[9];
    assign frameErrorOut  = headData[10];
    assign dataValid      = !fifoEmpty;

    // A simultaneous pop frees the slot, so only a true drop sets overflow.
    assign overflowSet = pushChar && fifoFull && !fifoPop;

    always_ff @(posedge clk) begin
        if (!rst) begin
            overflow      <= 1'b0;
            breakDetected <= 1'b0;
        end else begin
            if (overflowSet)     overflow <= 1'b1;
            else if (clearFlags) overflow <= 1'b0;
            if (setBreak)        breakDetected <= 1'b1;
            else if (clearFlags) breakDetected <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            silenceCnt <= '0;
        end else if (state == IDLE && rxSync) begin
            if (tick && silenceCnt != SILENCE_MAX) silenceCnt <= silenceCnt + SIL_W'(1);
        end else begin
            silenceCnt <= '0;
        end
    end

    assign silence = (silenceCnt == SILENCE_MAX);

endmodule
